// File: rtl/seq_det_ctrl.sv
// Serial sequence detector session controller: captures a pattern on start,
// counts overlapping matches in the din stream, ends on target/timeout/abort.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       pat_len,
  input  logic [CNT_W-1:0] hit_target,
  input  logic [TO_W-1:0]  timeout,
  input  logic             din,
  input  logic             din_valid,
  input  logic             abort,
  input  logic             done_ack,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  output logic             timed_out
);

  localparam int LW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, HUNT, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  // The oldest history bit is never compared, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0] sr_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    fill_q;
  logic [CNT_W-1:0] target_q;
  logic [TO_W-1:0]  to_q;
  logic [TO_W-1:0]  to_cnt;

  logic [PAT_W-1:0] sr_next;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    len_in;
  logic [CNT_W-1:0] cnt_next;
  logic [TO_W-1:0]  to_next;
  logic             match;
  logic             tgt_hit;
  logic             to_hit;

  always_comb begin
    len_in = LW'(pat_len);
    if (pat_len == '0 || int'(pat_len) > PAT_W) begin
      len_in = LW'(PAT_W);
    end
    sr_next = {sr_q, din};
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    match    = (state == HUNT) && din_valid &&
               (int'(fill_q) + 1 >= int'(len_q)) &&
               ((sr_next & mask) == (pat_q & mask));
    cnt_next = (hit_cnt == '1) ? hit_cnt : hit_cnt + 1'b1;
    to_next  = to_cnt + 1'b1;
    tgt_hit  = match && (target_q != '0) && (cnt_next == target_q);
    to_hit   = (to_q != '0) && (to_next == to_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_q     <= '0;
      sr_q      <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      target_q  <= '0;
      to_q      <= '0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      hit       <= 1'b0;
      hit_cnt   <= '0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hit <= 1'b0;
          if (start) begin
            pat_q     <= pat;
            len_q     <= len_in;
            target_q  <= hit_target;
            to_q      <= timeout;
            sr_q      <= '0;
            fill_q    <= '0;
            hit_cnt   <= '0;
            timed_out <= 1'b0;
            to_cnt    <= '0;
            busy      <= 1'b1;
            state     <= HUNT;
          end
        end
        HUNT: begin
          // Abort wins outright: the session is dropped without a hit or a result.
          if (abort) begin
            hit   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hit    <= match;
            to_cnt <= to_next;
            if (din_valid) begin
              sr_q <= sr_next[PAT_W-2:0];
              if (fill_q != len_q) fill_q <= fill_q + 1'b1;
            end
            if (match) hit_cnt <= cnt_next;
            if (tgt_hit) begin
              done      <= 1'b1;
              timed_out <= 1'b0;
              busy      <= 1'b0;
              state     <= DONE;
            end else if (to_hit) begin
              done      <= 1'b1;
              timed_out <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          hit <= 1'b0;
          if (done_ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          hit   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a bit-history model predicts each match and queues
// the expected hit_cnt; a negedge monitor pops it whenever hit pulses.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, start_b;
  logic [7:0]  pat;
  logic [3:0]  pat_len;
  logic [7:0]  hit_target;
  logic [15:0] timeout;
  logic        din, din_valid, abort, done_ack;

  logic        busy, hit, done, timed_out;
  logic [7:0]  hit_cnt;
  logic        busy_b, hit_b, done_b, timed_out_b;
  logic [1:0]  hit_cnt_b;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];

  logic [7:0] m_hist, m_pat;
  int         m_fill, m_len, m_cnt, m_max;
  bit         m_b;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat(pat), .pat_len(pat_len),
    .hit_target(hit_target), .timeout(timeout), .din(din), .din_valid(din_valid),
    .abort(abort), .done_ack(done_ack), .busy(busy), .hit(hit), .hit_cnt(hit_cnt),
    .done(done), .timed_out(timed_out)
  );

  seq_det_ctrl #(.PAT_W(8), .CNT_W(2), .TO_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pat(pat), .pat_len(pat_len),
    .hit_target(hit_target[1:0]), .timeout(timeout), .din(din), .din_valid(din_valid),
    .abort(abort), .done_ack(done_ack), .busy(busy_b), .hit(hit_b), .hit_cnt(hit_cnt_b),
    .done(done_b), .timed_out(timed_out_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [7:0] p, input logic [3:0] l, input logic [7:0] tg,
                               input logic [15:0] to, input bit use_b);
    pat = p; pat_len = l; hit_target = tg; timeout = to;
    if (use_b) start_b = 1'b1;
    else start = 1'b1;
    tick();
    start = 1'b0; start_b = 1'b0;
    m_pat = p; m_len = (l == 0 || l > 8) ? 8 : int'(l);
    m_hist = '0; m_fill = 0; m_cnt = 0; m_b = use_b; m_max = use_b ? 3 : 255;
  endtask

  task automatic send_bit(input logic b, input logic v, input logic ab);
    logic [7:0] mask;
    din = b; din_valid = v; abort = ab;
    mask = 8'((1 << m_len) - 1);
    if (v) begin
      m_hist = {m_hist[6:0], b};
      if (m_fill < m_len) m_fill++;
    end
    if (v && !ab && m_fill >= m_len && (m_hist & mask) == (m_pat & mask)) begin
      if (m_cnt < m_max) m_cnt++;
      if (m_b) exp_b_q.push_back(8'(m_cnt));
      else exp_q.push_back(8'(m_cnt));
    end
    tick();
    din = 1'b0; din_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic send_pat(input logic [7:0] p, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(p[i], 1'b1, 1'b0);
  endtask

  task automatic ack();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hit) begin
        if (exp_q.size() == 0) check("hit_unexpected_a", 32'd1, 32'd0);
        else check("hit_cnt_a", 32'(hit_cnt), 32'(exp_q.pop_front()));
      end
      if (hit_b) begin
        if (exp_b_q.size() == 0) check("hit_unexpected_b", 32'd1, 32'd0);
        else check("hit_cnt_b", 32'(hit_cnt_b), 32'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 0; start_b = 0; pat = '0; pat_len = '0; hit_target = '0; timeout = '0;
    din = 0; din_valid = 0; abort = 0; done_ack = 0;
    m_hist = '0; m_pat = '0; m_fill = 0; m_len = 8; m_cnt = 0; m_max = 255; m_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic 8-bit match, target 1
    start_session(8'b0101_0100, 4'd8, 8'd1, 16'd0, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    send_pat(8'b0101_0100, 8);
    check("t1_hit", 32'(hit), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_timed_out", 32'(timed_out), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    ack();
    check("t1_ack_done", 32'(done), 32'd0);

    // overlapping matches, unlimited target
    start_session(8'b101, 4'd3, 8'd0, 16'd0, 1'b0);
    send_pat(8'b10101, 5);
    check("t2_hit_cnt", 32'(hit_cnt), 32'd2);
    check("t2_busy", 32'(busy), 32'd1);
    send_bit(1'b0, 1'b0, 1'b1);
    check("t2_abort_busy", 32'(busy), 32'd0);
    check("t2_abort_done", 32'(done), 32'd0);
    check("t2_cnt_kept", 32'(hit_cnt), 32'd2);

    // gapped stream with timeout 10
    start_session(8'h0F, 4'd4, 8'd0, 16'd10, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b0, 1'(i % 2), 1'b0);
    check("t3_pre_done", 32'(done), 32'd0);
    check("t3_pre_busy", 32'(busy), 32'd1);
    send_bit(1'b0, 1'b1, 1'b0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_timed_out", 32'(timed_out), 32'd1);
    check("t3_hit_cnt", 32'(hit_cnt), 32'd0);
    ack();
    check("t3_ack_done", 32'(done), 32'd0);

    // match on the timeout edge: target reached, then not reached
    start_session(8'b1011, 4'd4, 8'd1, 16'd4, 1'b0);
    send_pat(8'b1011, 4);
    check("t4a_done", 32'(done), 32'd1);
    check("t4a_timed_out", 32'(timed_out), 32'd0);
    check("t4a_hit_cnt", 32'(hit_cnt), 32'd1);
    ack();
    start_session(8'b1011, 4'd4, 8'd3, 16'd4, 1'b0);
    send_pat(8'b1011, 4);
    check("t4b_done", 32'(done), 32'd1);
    check("t4b_timed_out", 32'(timed_out), 32'd1);
    check("t4b_hit_cnt", 32'(hit_cnt), 32'd1);
    ack();

    // abort on the matching edge
    start_session(8'b101, 4'd3, 8'd0, 16'd0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    check("t5a_busy", 32'(busy), 32'd0);
    check("t5a_hit", 32'(hit), 32'd0);
    check("t5a_hit_cnt", 32'(hit_cnt), 32'd0);
    tick();
    tick();
    check("t5a_done", 32'(done), 32'd0);

    // asynchronous reset mid-session
    start_session(8'b101, 4'd3, 8'd0, 16'd0, 1'b0);
    send_pat(8'b101, 3);
    @(negedge clk);
    check("t5b_pre_busy", 32'(busy), 32'd1);
    check("t5b_pre_cnt", 32'(hit_cnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5b_busy", 32'(busy), 32'd0);
    check("t5b_hit", 32'(hit), 32'd0);
    check("t5b_hit_cnt", 32'(hit_cnt), 32'd0);
    check("t5b_done", 32'(done), 32'd0);
    check("t5b_timed_out", 32'(timed_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // pat_len 0 clamps to the full 8-bit pattern
    start_session(8'b1100_1010, 4'd0, 8'd1, 16'd0, 1'b0);
    send_pat(8'b1100_1010, 8);
    check("t6a_done", 32'(done), 32'd1);
    check("t6a_hit_cnt", 32'(hit_cnt), 32'd1);
    check("t6a_timed_out", 32'(timed_out), 32'd0);
    ack();

    // 2-bit hit counter saturates at 3
    start_session(8'b1, 4'd1, 8'd0, 16'd0, 1'b1);
    repeat (5) send_bit(1'b1, 1'b1, 1'b0);
    check("t6b_sat", 32'(hit_cnt_b), 32'd3);
    check("t6b_busy", 32'(busy_b), 32'd1);
    send_bit(1'b0, 1'b0, 1'b1);
    check("t6b_abort_busy", 32'(busy_b), 32'd0);
    check("t6b_cnt_kept", 32'(hit_cnt_b), 32'd3);

    tick();
    check("q_empty", 32'(exp_q.size() + exp_b_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
